// File: rtl/rom_mul_arbiter.sv
// Two-requester 4x4 multiply via a shared synchronous ROM lookup. ROM_MUL_ARB_RR_EN selects round-robin over fixed priority.
// Latency: request accepted in IDLE, ACK three edges later. Throughput is one lookup per 4 cycles, and REQ is held until its ACK.
module rom_mul_arbiter #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic [3:0]    A0,
    input  logic [3:0]    B0,
    input  logic [3:0]    A1,
    input  logic [3:0]    B1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RESULT,
    output logic          BUSY,
    output logic [AW-1:0] ROM_ADDR,
    output logic          ROM_CS,
    output logic          ROM_RD,
    input  logic [DW-1:0] ROM_DATA
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic          gnt, gnt_nxt;
    logic [AW-1:0] addr_r, addr_nxt;
    logic [DW-1:0] result_r, result_nxt;
    logic          pick1;
    logic [7:0]    prod0, prod1;

    // Zero-extended operands keep the full 8-bit product.
    assign prod0 = {4'd0, A0} * {4'd0, B0};
    assign prod1 = {4'd0, A1} * {4'd0, B1};

`ifdef ROM_MUL_ARB_RR_EN
    logic last;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            last <= 1'b1;
        else if (state == DONE)
            last <= gnt;
    end

    assign pick1 = REQ1 && (!REQ0 || !last);
`else
    assign pick1 = REQ1 && !REQ0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            addr_r   <= '0;
            result_r <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            addr_r   <= addr_nxt;
            result_r <= result_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        addr_nxt   = addr_r;
        result_nxt = result_r;
        case (state)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    gnt_nxt   = pick1;
                    addr_nxt  = AW'(pick1 ? prod1 : prod0);
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                result_nxt = ROM_DATA;
                state_nxt  = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ACK0     = (state == DONE) && !gnt;
    assign ACK1     = (state == DONE) && gnt;
    assign BUSY     = (state != IDLE);
    assign ROM_CS   = (state == ISSUE);
    assign ROM_RD   = (state == ISSUE);
    assign ROM_ADDR = addr_r;
    assign RESULT   = result_r;

endmodule

// File: tb/tb_rom_mul_arbiter.sv
// Scoreboard bench for rom_mul_arbiter: directed requests, arbitration order, reset abort.
module tb_rom_mul_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       REQ0 = 1'b0, REQ1 = 1'b0;
    logic [3:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic       ACK0, ACK1, BUSY, ROM_CS, ROM_RD;
    logic [7:0] RESULT, ROM_ADDR, ROM_DATA;

    typedef struct packed {
        logic       who;
        logic [7:0] res;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] rom [256];
    logic [7:0] rom_q;
    logic       rom_v;

    rom_mul_arbiter #(.DW(8), .AW(8)) dut (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .ACK0(ACK0), .ACK1(ACK1), .RESULT(RESULT), .BUSY(BUSY),
        .ROM_ADDR(ROM_ADDR), .ROM_CS(ROM_CS), .ROM_RD(ROM_RD), .ROM_DATA(ROM_DATA)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Synchronous ROM, data valid only in the cycle after a read; X otherwise.
    always @(posedge CLK) begin
        rom_v <= ROM_CS && ROM_RD;
        rom_q <= rom[ROM_ADDR];
    end
    assign ROM_DATA = rom_v ? rom_q : 8'hxx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && (ACK0 || ACK1)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ACK0=%0b ACK1=%0b expected none", ACK0, ACK1);
                end else begin
                    e = sb.pop_front();
                    chk("sb_ack_who", ACK1, e.who);
                    chk("sb_ack_onehot", ACK0 & ACK1, 0);
                    chk("sb_result", RESULT, e.res);
                end
            end
        end
    endtask

    task automatic finish_req(input bit who, input logic [7:0] exp_addr, input logic [7:0] exp_res,
                              input int c0, input bit chg, input logic [3:0] a_new);
        bit found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge CLK);
            found = ROM_CS;
        end
        chk("rom_cs_seen", found, 1);
        if (!found) return;
        chk("rom_addr_issue", ROM_ADDR, exp_addr);
        chk("rom_rd_issue", ROM_RD, 1);
        chk("busy_issue", BUSY, 1);
        if (chg) begin
            if (who) A1 = a_new;
            else     A0 = a_new;
        end
        @(negedge CLK);
        chk("rom_cs_wait", ROM_CS, 0);
        chk("rom_rd_wait", ROM_RD, 0);
        chk("rom_addr_hold", ROM_ADDR, exp_addr);
        @(negedge CLK);
        chk(who ? "ack1_pulse" : "ack0_pulse", who ? ACK1 : ACK0, 1);
        chk("ack_other_low", who ? ACK0 : ACK1, 0);
        chk("latency", cyc - c0, 3);
        if (who) REQ1 = 1'b0;
        else     REQ0 = 1'b0;
        @(negedge CLK);
        chk("ack_clear", ACK0 | ACK1, 0);
        chk("busy_idle", BUSY, 0);
        chk("result_hold", RESULT, exp_res);
        chk("result_not_x", (^RESULT) === 1'bx, 0);
    endtask

    task automatic do_req(input bit who, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_addr, input logic [7:0] exp_res,
                          input bit chg, input logic [3:0] a_new);
        int c0;
        if (who) begin A1 = a; B1 = b; end
        else     begin A0 = a; B0 = b; end
        sb.push_back('{who, exp_res});
        if (who) REQ1 = 1'b1;
        else     REQ0 = 1'b1;
        c0 = cyc;
        finish_req(who, exp_addr, exp_res, c0, chg, a_new);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack0"}, ACK0, 0);
        chk({tag, "_ack1"}, ACK1, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_cs"}, ROM_CS, 0);
        chk({tag, "_rd"}, ROM_RD, 0);
        chk({tag, "_addr"}, ROM_ADDR, 0);
        chk({tag, "_result"}, RESULT, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int c0, t, tp;
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        rom[15] = 8'h0F;
        fork
            monitor();
        join_none

        #1 RST = 1'b1;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // who, A, B, addr, expected ROM word, change-A-in-ISSUE, new A
        do_req(0, 4'd3,  4'd5,  8'd15,  8'h0F, 0, 4'd0);
        do_req(1, 4'd15, 4'd15, 8'd225, 8'hBB, 0, 4'd0);
        do_req(0, 4'd0,  4'd9,  8'd0,   8'h5A, 0, 4'd0);
        do_req(1, 4'd6,  4'd4,  8'd24,  8'h42, 0, 4'd0);
        do_req(0, 4'd2,  4'd3,  8'd6,   8'h5C, 1, 4'd7);

        // Abort in WAIT, then serve a fresh request with REQ0 still held.
        A0 = 4'd1; B0 = 4'd11; REQ0 = 1'b1;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge CLK);
            found = ROM_CS;
        end
        chk("abort_rom_cs_seen", found, 1);
        chk("abort_rom_addr", ROM_ADDR, 11);
        @(posedge CLK);
        #1 RST = 1'b1;
        #1 chk_all_zero("abort");
        @(negedge CLK);
        A0 = 4'd13; B0 = 4'd12;
        @(negedge CLK);
        RST = 1'b0;
        sb.push_back('{1'b0, 8'hC6});
        c0 = cyc;
        finish_req(0, 8'd156, 8'hC6, c0, 0, 4'd0);

        // Both held high from a fresh pointer.
        @(negedge CLK) RST = 1'b1;
        @(negedge CLK) RST = 1'b0;
        A0 = 4'd4; B0 = 4'd5; A1 = 4'd9; B1 = 4'd9;
`ifdef ROM_MUL_ARB_RR_EN
        sb.push_back('{1'b0, 8'h4E});
        sb.push_back('{1'b1, 8'h0B});
        sb.push_back('{1'b0, 8'h4E});
        sb.push_back('{1'b1, 8'h0B});
`else
        for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 8'h4E});
`endif
        REQ0 = 1'b1; REQ1 = 1'b1;
        c0 = cyc;
        tp = c0;
        for (int i = 0; i < 4; i++) begin
            found = 0;
            for (int k = 0; k < 12 && !found; k++) begin
                @(negedge CLK);
                found = ACK0 | ACK1;
            end
            chk("held_ack_seen", found, 1);
            if (!found) break;
            t = cyc;
            if (i == 0) chk("held_latency", t - c0, 3);
            else        chk("held_spacing", t - tp, 4);
            tp = t;
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        @(negedge CLK);

        // Lone requester 1 is granted whatever the pointer says.
        do_req(1, 4'd5, 4'd5, 8'd25, 8'h43, 0, 4'd0);

        repeat (2) @(negedge CLK);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
